// File: rtl/cmd_seq_pkg.sv
// Shared types and constants for the command RAM packet sequencer.
package cmd_seq_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;

  // The length field lives in the low ADDR_W bits of the header word.
  localparam int LEN_LSB = 0;
  localparam int LEN_MSB = DEF_ADDR_W - 1;

  typedef enum logic [2:0] {
    IDLE,
    HDR_RD,
    HDR_WAIT,
    STREAM,
    DRAIN,
    DONE
  } cmd_seq_state_t;

endpackage

// File: rtl/cmd_seq_skid_fifo.sv
// Two-entry synchronous FIFO on the RAM return path; the head entry is
// presented straight from storage registers.
module cmd_seq_skid_fifo #(
  parameter int W = 34
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  logic         w_pop;
  logic         w_push;

  assign w_pop  = i_pop & (r_count != 2'd0);
  assign w_push = i_push & ((r_count != 2'd2) | w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/cmd_ram_sequencer.sv
// Command RAM packet sequencer: reads a length header at the start address,
// then streams that many payload words onto an Avalon-ST source.
module cmd_ram_sequencer
  import cmd_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_send_cmd,
  input  logic [ADDR_W-1:0] i_start_ram_addr,
  input  logic              i_ddr_setup_done,
  output logic              o_ram_rd_en,
  output logic [ADDR_W-1:0] o_ram_rd_addr,
  input  logic [DATA_W-1:0] i_ram_rd_data,
  output logic [DATA_W-1:0] o_st_data,
  output logic              o_st_valid,
  input  logic              i_st_ready,
  output logic              o_st_sop,
  output logic              o_st_eop,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_len
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  cmd_seq_state_t    r_state;
  logic              r_send_cmd_d;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_issue_cnt;
  logic [ADDR_W-1:0] r_out_cnt;
  logic              r_inflight;
  logic              r_inflight_sop;
  logic              r_inflight_eop;
  logic              r_busy;
  logic              r_done;

  logic              w_trigger;
  logic              w_pop;
  logic              w_room;
  logic              w_issue;
  logic              w_last_issue;
  logic              w_last_pop;
  logic [ADDR_W-1:0] w_hdr_len;
  logic [1:0]        w_fifo_count;
  logic [2:0]        w_level;
  logic [DATA_W+1:0] w_head;
  logic              w_head_valid;

  assign w_hdr_len = i_ram_rd_data[LEN_LSB +: ADDR_W];
  assign w_trigger = (r_state == IDLE) & i_send_cmd & ~r_send_cmd_d & i_ddr_setup_done;
  assign w_pop     = w_head_valid & i_st_ready;

  // A read in flight already owns a FIFO slot, so returning data always fits.
  assign w_level      = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_room       = (w_level < 3'd2);
  assign w_issue      = (r_state == STREAM) & (r_issue_cnt != r_len) & w_room;
  assign w_last_issue = w_issue & (r_issue_cnt == r_len - ONE);
  assign w_last_pop   = w_pop & (r_out_cnt == r_len - ONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_send_cmd_d   <= 1'b0;
      r_addr         <= '0;
      r_len          <= '0;
      r_issue_cnt    <= '0;
      r_out_cnt      <= '0;
      r_inflight     <= 1'b0;
      r_inflight_sop <= 1'b0;
      r_inflight_eop <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_send_cmd_d   <= i_send_cmd;
      r_done         <= 1'b0;
      r_inflight     <= w_issue;
      r_inflight_sop <= w_issue & (r_issue_cnt == '0);
      r_inflight_eop <= w_last_issue;
      if (w_pop) begin
        r_out_cnt <= r_out_cnt + ONE;
      end
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_addr  <= i_start_ram_addr;
            r_busy  <= 1'b1;
            r_state <= HDR_RD;
          end
        end
        HDR_RD: begin
          r_state <= HDR_WAIT;
        end
        HDR_WAIT: begin
          r_len       <= w_hdr_len;
          r_issue_cnt <= '0;
          r_out_cnt   <= '0;
          if (w_hdr_len == '0) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_addr  <= r_addr + ONE;
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (w_issue) begin
            r_addr      <= r_addr + ONE;
            r_issue_cnt <= r_issue_cnt + ONE;
          end
          if (w_last_issue) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_last_pop) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  cmd_seq_skid_fifo #(
    .W(DATA_W + 2)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (r_inflight),
    .i_data  ({r_inflight_sop, r_inflight_eop, i_ram_rd_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (w_head_valid),
    .o_count (w_fifo_count)
  );

  // The header arrives combinationally in HDR_WAIT, so the length error is decoded there.
  assign o_err_len     = (r_state == HDR_WAIT) & (w_hdr_len == '0);
  assign o_ram_rd_en   = (r_state == HDR_RD) | w_issue;
  assign o_ram_rd_addr = r_addr;
  assign o_st_data     = w_head[DATA_W-1:0];
  assign o_st_valid    = w_head_valid;
  assign o_st_sop      = w_head_valid & w_head[DATA_W+1];
  assign o_st_eop      = w_head_valid & w_head[DATA_W];
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule

// File: tb/tb_cmd_ram_sequencer.sv
// Scoreboard bench for cmd_ram_sequencer: a RAM model plus expected read
// addresses and stream words queued at stimulus time, checked by a monitor.
module tb_cmd_ram_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        send_cmd = 1'b0;
  logic [5:0]  startAddr = '0;
  logic        ddr = 1'b1;
  logic        rdEn;
  logic [5:0]  rdAddr;
  logic [31:0] rdData = '0;
  logic [31:0] stData;
  logic        stValid;
  logic        stReady = 1'b1;
  logic        stSop;
  logic        stEop;
  logic        busy;
  logic        done;
  logic        errLen;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } expWord_t;

  expWord_t    expQ[$];
  logic [5:0]  expAddrQ[$];
  int          rdLog[$];
  int          xferLog[$];
  logic [31:0] ram [64];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int doneCount = 0;
  int errCount = 0;
  int xferCount = 0;
  int busyCycles = 0;
  int doneCyc = 0;
  int errCyc = 0;
  int lastXferCyc = 0;
  int readyMode = 0;
  int tBasic;

  cmd_ram_sequencer dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_send_cmd       (send_cmd),
    .i_start_ram_addr (startAddr),
    .i_ddr_setup_done (ddr),
    .o_ram_rd_en      (rdEn),
    .o_ram_rd_addr    (rdAddr),
    .i_ram_rd_data    (rdData),
    .o_st_data        (stData),
    .o_st_valid       (stValid),
    .i_st_ready       (stReady),
    .o_st_sop         (stSop),
    .o_st_eop         (stEop),
    .o_busy           (busy),
    .o_done           (done),
    .o_err_len        (errLen)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM model: data appears one cycle after the strobe.
  always @(posedge clk) begin
    if (rdEn) rdData <= ram[rdAddr];
  end

  task automatic reportFail(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ready pattern generator: 0 = always ready, 1 = random, 2 = 1,0,0,1,0,1 repeating.
  initial begin
    int idx;
    bit pattern [6];
    pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    idx = 0;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        1: stReady = 1'($urandom_range(0, 1));
        2: begin
          stReady = pattern[idx % 6];
          idx++;
        end
        default: stReady = 1'b1;
      endcase
    end
  end

  // Monitor: compares reads and stream transfers against the scoreboard queues.
  initial begin
    bit          stallPrev;
    logic [33:0] heldWord;
    expWord_t    w;
    stallPrev = 1'b0;
    heldWord  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stallPrev = 1'b0;
      end else begin
        if (rdEn) begin
          rdLog.push_back(cyc);
          if (expAddrQ.size() == 0) reportFail("unexpected_read", rdAddr, 0);
          else checkOutput("rd_addr", rdAddr, expAddrQ.pop_front());
        end
        if (stValid) begin
          if (stallPrev) checkOutput("stall_hold", {stData, stSop, stEop}, heldWord);
          if (expQ.size() == 0) begin
            reportFail("unexpected_word", stData, 0);
          end else if (stReady) begin
            w = expQ.pop_front();
            checkOutput("st_data", stData, w.data);
            checkOutput("st_sop", stSop, w.sop);
            checkOutput("st_eop", stEop, w.eop);
            xferCount++;
            lastXferCyc = cyc;
            xferLog.push_back(cyc);
          end
          stallPrev = !stReady;
          heldWord  = {stData, stSop, stEop};
        end else begin
          if (stallPrev) reportFail("valid_dropped_while_stalled", 0, 1);
          stallPrev = 1'b0;
        end
        if (done) begin
          doneCount++;
          doneCyc = cyc;
        end
        if (errLen) begin
          errCount++;
          errCyc = cyc;
        end
        if (busy) busyCycles++;
      end
    end
  end

  // Fill the RAM for one packet and queue the expected reads and words.
  task automatic loadPacket(input logic [5:0] s, input int len, input int base);
    logic [31:0] hdr;
    logic [5:0]  a;
    expWord_t    w;
    hdr      = $urandom;
    hdr[5:0] = 6'(len);
    ram[s]   = hdr;
    expAddrQ.push_back(s);
    for (int i = 1; i <= len; i++) begin
      a = s + 6'(i);
      ram[a] = (base != 0) ? 32'(base + i - 1) : $urandom;
      expAddrQ.push_back(a);
      w.data = ram[a];
      w.sop  = (i == 1);
      w.eop  = (i == len);
      expQ.push_back(w);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] s, input int len, input int base,
                               input bit holdCmd, input bit dropEnable, input bit toggleMid,
                               output int tOut);
    int d0, e0, x0, b0, r0, t, n;
    d0 = doneCount;
    e0 = errCount;
    x0 = xferCount;
    b0 = busyCycles;
    loadPacket(s, len, base);
    @(posedge clk);
    #1;
    startAddr = s;
    send_cmd  = 1'b1;
    t = cyc;
    @(posedge clk);
    #1;
    startAddr = 6'($urandom);
    if (!holdCmd) send_cmd = 1'b0;
    n = 0;
    while (doneCount == d0 && errCount == e0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (dropEnable && n == 3) ddr = 1'b0;
      if (toggleMid) begin
        case (n)
          4: send_cmd = 1'b0;
          6: send_cmd = 1'b1;
          8: send_cmd = 1'b0;
          default: ;
        endcase
      end
    end
    if (n >= 3000) begin
      reportFail("timeout_waiting_done", n, 0);
    end else begin
      checkOutput("busy_after_end", busy, 0);
      if (len == 0) begin
        checkOutput("err_len_cycle", errCyc, t + 2);
        checkOutput("no_done_on_err", doneCount - d0, 0);
        checkOutput("busy_span_err", busyCycles - b0, 2);
      end else begin
        checkOutput("done_count", doneCount - d0, 1);
        checkOutput("no_err_len", errCount - e0, 0);
        checkOutput("xfer_count", xferCount - x0, len);
        checkOutput("done_after_eop", doneCyc, lastXferCyc + 1);
        checkOutput("busy_span", busyCycles - b0, doneCyc - t);
        if (readyMode == 0) checkOutput("done_cycle", doneCyc, t + 5 + len);
      end
    end
    checkOutput("words_left", expQ.size(), 0);
    checkOutput("reads_left", expAddrQ.size(), 0);
    if (holdCmd || toggleMid) begin
      r0 = rdLog.size();
      b0 = busyCycles;
      repeat (15) @(posedge clk);
      #1;
      checkOutput("no_retrigger_reads", rdLog.size() - r0, 0);
      checkOutput("no_retrigger_busy", busyCycles - b0, 0);
    end
    send_cmd = 1'b0;
    ddr      = 1'b1;
    tOut     = t;
  endtask

  initial begin
    int t, x0, r0, b0, n, len;
    logic [5:0] s;

    for (int i = 0; i < 64; i++) ram[i] = $urandom;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
                {rdEn, rdAddr, stData, stValid, stSop, stEop, busy, done, errLen}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] basic packet S=5 LEN=3");
    rdLog.delete();
    xferLog.delete();
    applyStimulus(6'd5, 3, 32'hA0, 1'b0, 1'b0, 1'b0, tBasic);
    checkOutput("basic_read_count", rdLog.size(), 4);
    if (rdLog.size() == 4) begin
      checkOutput("basic_hdr_rd_cyc", rdLog[0], tBasic + 1);
      checkOutput("basic_rd1_cyc", rdLog[1], tBasic + 3);
      checkOutput("basic_rd3_cyc", rdLog[3], tBasic + 5);
    end
    checkOutput("basic_xfer_count", xferLog.size(), 3);
    if (xferLog.size() == 3) begin
      checkOutput("basic_first_word_cyc", xferLog[0], tBasic + 5);
      checkOutput("basic_eop_cyc", xferLog[2], tBasic + 7);
    end

    $display("[TB] address wrap S=62 LEN=3");
    applyStimulus(6'd62, 3, 0, 1'b0, 1'b0, 1'b0, t);

    $display("[TB] backpressure LEN=8");
    readyMode = 2;
    applyStimulus(6'($urandom), 8, 0, 1'b0, 1'b0, 1'b0, t);
    readyMode = 0;

    $display("[TB] zero length, then held level");
    applyStimulus(6'd20, 0, 0, 1'b0, 1'b0, 1'b0, t);
    applyStimulus(6'd30, 4, 0, 1'b1, 1'b0, 1'b0, t);

    $display("[TB] second rise mid-packet");
    applyStimulus(6'd40, 10, 0, 1'b0, 1'b0, 1'b1, t);

    $display("[TB] enable gating");
    ddr = 1'b0;
    r0 = rdLog.size();
    b0 = busyCycles;
    @(posedge clk);
    #1 send_cmd = 1'b1;
    @(posedge clk);
    #1 send_cmd = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("gated_no_read", rdLog.size() - r0, 0);
    checkOutput("gated_no_busy", busyCycles - b0, 0);
    ddr = 1'b1;
    applyStimulus(6'd50, 12, 0, 1'b0, 1'b1, 1'b0, t);

    $display("[TB] reset mid-stream");
    x0 = xferCount;
    loadPacket(6'd10, 6, 0);
    @(posedge clk);
    #1;
    startAddr = 6'd10;
    send_cmd  = 1'b1;
    @(posedge clk);
    #1 send_cmd = 1'b0;
    n = 0;
    while (xferCount - x0 < 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) reportFail("timeout_waiting_xfers", xferCount - x0, 2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_outputs",
                {rdEn, rdAddr, stData, stValid, stSop, stEop, busy, done, errLen}, 0);
    expQ.delete();
    expAddrQ.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(6'd10, 6, 0, 1'b0, 1'b0, 1'b0, t);

    $display("[TB] randomized packets");
    for (int k = 0; k < 12; k++) begin
      readyMode = $urandom_range(0, 2);
      s = 6'($urandom);
      len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63);
      applyStimulus(s, len, 0, 1'b0, 1'b0, 1'b0, t);
    end
    readyMode = 0;

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_watchdog actual=%0d expected=finished", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cmd_ram_sequencer.md
# cmd_ram_sequencer

Sequences one command-packet transmission out of the 64-entry command RAM. It is triggered by the `send_cmd` bit and starts at the `start_ram_addr` field, both driven by the CSR slave (send-packet register, bits 5 and 13:8). It reads a header word, then streams that many payload words onto an Avalon-ST source with SOP/EOP framing. It sits between the CSR slave, the command RAM read port and the packet transmitter. Transmission is gated by `ddr_setup_done`.

## Interface
- `ADDR_W`, 6, command RAM address width; addresses wrap modulo 2^ADDR_W
- `DATA_W`, 32, RAM word and stream data width
- `clk` in 1: single clock for all logic
- `rst_n` in 1: asynchronous, active-low reset
- `send_cmd` in 1: level from CSR; its rising edge requests a packet
- `start_ram_addr` in ADDR_W: header word address; sampled on the trigger cycle
- `ddr_setup_done` in 1: enable; a trigger is accepted only while this is 1
- `ram_rd_en` out 1: RAM read strobe
- `ram_rd_addr` out ADDR_W: RAM read address
- `ram_rd_data` in DATA_W: valid exactly 1 cycle after `ram_rd_en`
- `st_data` out DATA_W: stream data
- `st_valid` out 1: stream valid
- `st_ready` in 1: stream ready; a transfer occurs when `st_valid` & `st_ready`
- `st_sop` out 1: first word of the packet, qualified by `st_valid`
- `st_eop` out 1: last word of the packet, qualified by `st_valid`
- `busy` out 1: packet in progress
- `done` out 1: one-cycle pulse after the EOP transfer
- `err_len` out 1: one-cycle pulse when the header length is 0

## Operation
- **Edge detect:** `send_cmd` is registered once. The trigger is `send_cmd & ~send_cmd_d & ddr_setup_done` while in IDLE. Edges seen in any other state are ignored and are not queued. Holding the level does not retrigger.
- **Header format:** `LEN = hdr[ADDR_W-1:0]` gives the number of payload words, 1..63. Header bits above that are reserved and ignored. The header word itself is not transmitted.
- **Payload location:** payload word i (i = 1..LEN) is at `(S + i) mod 64`, where S is the sampled start address.
- **FSM states:**
  - IDLE: on trigger, latch S and go to HDR_RD.
  - HDR_RD: assert `ram_rd_en` with addr=S; go to HDR_WAIT.
  - HDR_WAIT: capture LEN. If LEN=0, pulse `err_len` and go to IDLE. Otherwise go to STREAM.
  - STREAM: issue payload reads until LEN reads have been issued; then go to DRAIN.
  - DRAIN: wait for the EOP transfer; then go to DONE.
  - DONE: pulse `done`; go to IDLE.
- **Buffering:** a 2-entry FIFO sits on the RAM return path.
  - A read is issued only if (occupancy + in-flight − pop this cycle) < 2.
  - The FIFO never overflows, and no RAM data is dropped.
- **Framing:** `st_sop` is set on payload word 1 and `st_eop` on word LEN; for LEN=1 both are set.
  - A 6-bit issue counter and a 6-bit output counter track progress; both count to LEN exactly.
- **Enable mid-packet:** `ddr_setup_done` falling during a packet does not abort it; the packet completes.
- **Backpressure:** while `st_valid`=1 and `st_ready`=0, `st_data`, `st_sop` and `st_eop` are held stable.

## Timing
- **Reset values:** every output is 0, the FSM is IDLE, the FIFO is empty and `send_cmd_d` is 0. Reset acts immediately, including mid-packet; no partial packet resumes afterwards.
- **Trigger to header:** the trigger is sampled in cycle T. In T+1, `ram_rd_en`=1 with addr=S. In T+2, the header is captured.
- **First payload word:** first payload read in T+3, data returned in T+4, `st_valid`=1 with `st_sop` in T+5 (FIFO output is registered).
- **Throughput:** with `st_ready` held high, one word per cycle. The EOP transfer is at T+4+LEN.
- **Completion:** `done` pulses in the cycle after the EOP transfer.
- **`busy`:** high from T+1 through the `done` cycle inclusive. On the LEN=0 path it is high for T+1..T+2, with `err_len` in T+2.
- **Next trigger:** accepted no earlier than the cycle after `done` or `err_len`.

## Structure
- **Package `cmd_seq_pkg`:**
  - state enum `cmd_seq_state_t` (IDLE, HDR_RD, HDR_WAIT, STREAM, DRAIN, DONE)
  - `LEN_LSB`/`LEN_MSB` header field constants
  - default `ADDR_W`/`DATA_W`
- **Sub-module `cmd_seq_skid_fifo`:** 2-entry synchronous FIFO carrying {sop, eop, data}, with `count` output, async active-low reset.
- **Top-level logic:** FSM, counters, address generator and edge detect.

## Test plan
- **Basic packet:** S=5, RAM[5]=3, RAM[6..8]=A0,A1,A2, `st_ready`=1, trigger at T. Expect reads at addr 5,6,7,8 in T+1, T+3..T+5; stream A0(sop),A1,A2(eop) in T+5..T+7; `done` at T+8; `busy` low at T+9.
- **Address wrap:** S=62, LEN=3. Expect reads at addr 62,63,0,1; three words with correct framing.
- **Backpressure:** LEN=8, `st_ready` pattern 1,0,0,1,0,1… Expect all 8 words in order, no duplicates, data stable while stalled, FIFO count never above 2.
- **Zero length and retrigger:** LEN=0 → `err_len` at T+2, no `st_valid`, `busy` low at T+3. Then `send_cmd` held high, and a second rise mid-packet → no additional packet.
- **Enable gating:** `ddr_setup_done`=0 at the edge → no read, no `busy`. Enable dropped mid-packet → packet still completes with `done`.
- **Reset mid-stream:** `rst_n` asserted after 2 of 6 words → all outputs 0 immediately. After release, a new trigger yields a full, correct packet.
